// File: rtl/sram_wb_pkg.sv
// -----------------------------------------------------------------------------
// sram_wb_pkg
// Shared types and constants for the SRAM posted-write buffer.
//   wb_state_t : drain/read sequencing states (IDLE, DRAIN, READ)
//   wb_entry_t : one buffered write {addr, data}
//   LINE_LSB   : lowest address bit that selects a 64-bit SRAM line
//   same_line  : true when two byte addresses fall in the same SRAM line
// -----------------------------------------------------------------------------
package sram_wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam int LINE_LSB = 3;

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return (a[31:LINE_LSB] == b[31:LINE_LSB]);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Circular store of posted writes with line-hit lookup and tail coalescing.
// Optional feature macro: WB_COALESCE_EN (enables the tail_match compare).
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push          : enqueue push_entry at tail
//   pop           : dequeue head
//   coalesce      : overwrite data of the tail-most valid entry
//   push_entry    : entry to enqueue / data to coalesce
//   lookup_addr   : upstream address used for line-hit and tail compares
//   head_entry    : oldest entry (next to drain)
//   count         : number of valid entries
//   line_hit      : some valid entry lies in lookup_addr's SRAM line
//   tail_match    : tail-most valid entry has exactly lookup_addr
// -----------------------------------------------------------------------------
module wb_fifo
    import sram_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   coalesce,
    input  wb_entry_t              push_entry,
    input  logic [31:0]            lookup_addr,
    output wb_entry_t              head_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   line_hit,
    output logic                   tail_match
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

    wb_entry_t         mem_r [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic [PW-1:0]     tail_m1_s;
    logic [DEPTH-1:0]  hit_vec_s;

    assign tail_m1_s  = tail_r - PTR_ONE;
    assign head_entry = mem_r[head_r];
    assign count      = count_r;
    assign line_hit   = |hit_vec_s;

    // Entry i is valid when its distance from head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] offset_s;
        logic          valid_s;
        assign offset_s     = PW'(g) - head_r;
        assign valid_s      = ({1'b0, offset_s} < count_r);
        assign hit_vec_s[g] = valid_s && same_line(mem_r[g].addr, lookup_addr);
    end

`ifdef WB_COALESCE_EN
    assign tail_match = (count_r != CNT_ZERO) && (mem_r[tail_m1_s].addr == lookup_addr);
`else
    assign tail_match = 1'b0;
`endif

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= '{default: 1'b0};
            tail_r  <= '{default: 1'b0};
            count_r <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{addr: 32'h0000_0000, data: 32'h0000_0000};
            end
        end else begin
            if (push) begin
                mem_r[tail_r] <= push_entry;
                tail_r        <= tail_r + PTR_ONE;
            end else if (coalesce) begin
                mem_r[tail_m1_s].data <= push_entry.data;
            end
            if (pop) begin
                head_r <= head_r + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_write_buffer.sv
// -----------------------------------------------------------------------------
// sram_write_buffer
// Posted-write buffer between the data-cache controller and the SRAM
// controller. Stores retire upstream immediately and drain in the background;
// reads bypass the queue unless a queued write shares their 64-bit line, in
// which case the queue drains until the conflict is gone.
// Optional feature macro: WB_COALESCE_EN (a write to the tail entry's address
// overwrites that entry instead of allocating).
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en, rd_en  : upstream requests, held until ready
//   address       : upstream byte address (word aligned)
//   write_data    : upstream store data
//   ready         : upstream request completes this cycle
//   read_data     : line data, valid with ready on a read
//   sram_wr_en    : downstream write request (held until sram_ready)
//   sram_rd_en    : downstream read request (held until sram_ready)
//   sram_address  : downstream address
//   sram_wdata    : downstream write data
//   sram_ready    : downstream completion pulse
//   sram_rdata    : downstream read data, valid with sram_ready
// -----------------------------------------------------------------------------
module sram_write_buffer
    import sram_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic [63:0] read_data,
    output logic        sram_wr_en,
    output logic        sram_rd_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic        sram_ready,
    input  logic [63:0] sram_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    wb_state_t     state_r;
    wb_state_t     state_next_s;
    logic          push_s;
    logic          pop_s;
    logic          coalesce_s;
    wb_entry_t     push_entry_s;
    wb_entry_t     head_s;
    logic [CW-1:0] count_s;
    logic          line_hit_s;
    logic          tail_match_s;
    logic          wr_req_s;
    logic          coal_ok_s;

    assign push_entry_s = '{addr: address, data: write_data};

    // Write/read together means the read wins; ready is forced low in reset.
    assign wr_req_s = wr_en && !rd_en && !rst;

    // The entry being presented to SRAM must not change under the drain.
    assign coal_ok_s = tail_match_s && !((state_r == DRAIN) && (count_s == CNT_ONE));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push_s),
        .pop         (pop_s),
        .coalesce    (coalesce_s),
        .push_entry  (push_entry_s),
        .lookup_addr (address),
        .head_entry  (head_s),
        .count       (count_s),
        .line_hit    (line_hit_s),
        .tail_match  (tail_match_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Write acceptance, next-state selection and downstream request muxing.
    always_comb begin
        state_next_s = state_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        coalesce_s   = 1'b0;
        ready        = 1'b0;
        read_data    = 64'h0000_0000_0000_0000;
        sram_wr_en   = 1'b0;
        sram_rd_en   = 1'b0;
        sram_address = 32'h0000_0000;
        sram_wdata   = 32'h0000_0000;

        // Acceptance depends only on registered occupancy, so a full buffer
        // accepts one cycle after the drain that frees a slot.
        if (wr_req_s && coal_ok_s) begin
            ready      = 1'b1;
            coalesce_s = 1'b1;
        end else if (wr_req_s && (count_s < CNT_FULL)) begin
            ready  = 1'b1;
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (rd_en && !line_hit_s) begin
                    state_next_s = READ;
                end else if (count_s != CNT_ZERO) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                sram_wr_en   = 1'b1;
                sram_address = head_s.addr;
                sram_wdata   = head_s.data;
                if (sram_ready) begin
                    pop_s        = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            READ: begin
                sram_rd_en   = 1'b1;
                sram_address = address;
                if (sram_ready) begin
                    ready        = 1'b1;
                    read_data    = sram_rdata;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = READ;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_write_buffer.sv
// -----------------------------------------------------------------------------
// tb_sram_write_buffer
// Directed scenarios followed by a randomized phase. The bench keeps the
// buffer contents as a queue of {addr,data}, acts as the SRAM slave with a
// configurable latency, and checks every cycle's upstream/downstream activity
// against the ordering and acceptance rules of the write buffer.
// -----------------------------------------------------------------------------
module tb_sram_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;
    logic [63:0] read_data;
    logic        sram_wr_en;
    logic        sram_rd_en;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        sram_ready;
    logic [63:0] sram_rdata;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          lat_min = 0;
    int          lat_max = 3;
    int          lat_cnt = 0;
    int          lat_tgt = 0;
    logic        req_prev = 1'b0;
    logic        prev_idle_nonempty = 1'b0;
    logic        prev_rd_nohit = 1'b0;
    logic        last_ready = 1'b0;
    int          wr50_count = 0;
    logic [31:0] last_drain_addr = 32'h0;

    sram_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .address      (address),
        .write_data   (write_data),
        .ready        (ready),
        .read_data    (read_data),
        .sram_wr_en   (sram_wr_en),
        .sram_rd_en   (sram_rd_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_ready   (sram_ready),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] line_data(input logic [31:0] a);
        if (a == 32'h0000_0300) return 64'h1122_3344_5566_7788;
        return {~a, a} ^ 64'h0f0f_0000_5a5a_0000;
    endfunction

    function automatic logic model_hit(input logic [31:0] a);
        foreach (q[i]) begin
            if (q[i].a[31:3] == a[31:3]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: SRAM response, checks, then model update at the edge.
    task automatic step();
        logic req_now, hit_now, read_done, drained, coal, acc, exp_ready;
        @(negedge clk);
        req_now = sram_wr_en | sram_rd_en;
        if (req_now && !req_prev) begin
            lat_cnt = 0;
            lat_tgt = int'($urandom_range(lat_max, lat_min));
        end else if (req_now) begin
            lat_cnt++;
        end
        sram_ready = req_now && (lat_cnt >= lat_tgt);
        sram_rdata = sram_ready ? line_data(sram_address) : {$urandom(), $urandom()};
        #1;
        hit_now = model_hit(address);
        chk("one_req", 64'(sram_wr_en & sram_rd_en), 64'd0);
        if (prev_idle_nonempty) chk("drain_start", 64'(req_now), 64'd1);
        if (prev_rd_nohit) chk("rd_issue", 64'(sram_rd_en), 64'd1);
        if (sram_wr_en) begin
            if (q.size() == 0) begin
                chk("wr_spurious", 64'(sram_wr_en), 64'd0);
            end else begin
                chk("drain_addr", 64'(sram_address), 64'(q[0].a));
                chk("drain_data", 64'(sram_wdata), 64'(q[0].d));
            end
        end
        if (sram_rd_en) begin
            chk("rd_addr", 64'(sram_address), 64'(address));
            chk("rd_raw", 64'(hit_now), 64'd0);
        end
        if (!req_now) begin
            chk("idle_addr", 64'(sram_address), 64'd0);
            chk("idle_wdata", 64'(sram_wdata), 64'd0);
        end
        read_done = rd_en && sram_rd_en && sram_ready;
        drained   = sram_wr_en && sram_ready;
        coal      = 1'b0;
`ifdef WB_COALESCE_EN
        if (wr_en && !rd_en && (q.size() > 0)) begin
            if ((q[$].a == address) && !((q.size() == 1) && sram_wr_en)) coal = 1'b1;
        end
`endif
        acc       = wr_en && !rd_en && (coal || (q.size() < DEPTH));
        exp_ready = acc || read_done;
        chk("ready", 64'(ready), 64'(exp_ready));
        if (read_done) chk("read_data", read_data, line_data(address));
        last_ready         = ready;
        prev_idle_nonempty = !req_now && (q.size() > 0);
        prev_rd_nohit      = !req_now && rd_en && !hit_now;
        if (drained) begin
            last_drain_addr = sram_address;
            if (sram_address == 32'h0000_0050) wr50_count++;
        end
        req_prev = req_now;
        @(posedge clk);
        if (drained && (q.size() > 0)) void'(q.pop_front());
        if (acc) begin
            if (coal) q[$].d = write_data;
            else q.push_back('{a: address, d: write_data});
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; sram_ready = 1'b0; rst = 1'b1;
        #1;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rdata", read_data, 64'd0);
        chk("rst_sram_wr", 64'(sram_wr_en), 64'd0);
        chk("rst_sram_rd", 64'(sram_rd_en), 64'd0);
        chk("rst_sram_addr", 64'(sram_address), 64'd0);
        chk("rst_sram_wdata", 64'(sram_wdata), 64'd0);
        q.delete();
        req_prev = 1'b0; lat_cnt = 0;
        prev_idle_nonempty = 1'b0; prev_rd_nohit = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int waited);
        logic done = 1'b0;
        wr_en = 1'b1; address = a; write_data = d; waited = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (last_ready) begin done = 1'b1; break; end
            waited++;
        end
        if (!done) chk("wr_timeout", 64'(done), 64'd1);
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output int waited);
        logic done = 1'b0;
        rd_en = 1'b1; address = a; waited = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (last_ready) begin done = 1'b1; break; end
            waited++;
        end
        if (!done) chk("rd_timeout", 64'(done), 64'd1);
        rd_en = 1'b0;
    endtask

    task automatic drain_all();
        logic done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if ((q.size() == 0) && !sram_wr_en && !sram_rd_en) begin done = 1'b1; break; end
            step();
        end
        if (!done) chk("drain_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        int w;
        int exp50;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        address = 32'h0; write_data = 32'h0;
        sram_ready = 1'b0; sram_rdata = 64'h0;

        // Reset values.
        do_reset();

        // Four back-to-back writes, each accepted in its request cycle.
        lat_min = 0; lat_max = 3;
        for (int i = 0; i < 4; i++) begin
            do_write(32'h10 + 32'(i * 4), 32'hA0 + 32'(i), w);
            chk("b2b_lat", 64'(w), 64'd0);
        end
        drain_all();

        // Fill, then a fifth write waits for the first drain to finish.
        lat_min = 6; lat_max = 6;
        for (int i = 0; i < 4; i++) begin
            do_write(32'h20 + 32'(i * 4), 32'hB0 + 32'(i), w);
        end
        do_write(32'h40, 32'hB4, w);
        chk("full_wait", 64'(w), 64'd5);
        drain_all();
        chk("full_last", 64'(last_drain_addr), 64'h40);

        // Read to an unrelated line preempts the second queued write.
        lat_min = 3; lat_max = 3;
        do_write(32'h100, 32'hC0, w);
        do_write(32'h200, 32'hC1, w);
        do_read(32'h300, w);
        chk("preempt_left", 64'(q.size()), 64'd1);
        if (q.size() == 1) chk("preempt_addr", 64'(q[0].a), 64'h200);
        drain_all();

        // Same-line read waits for the conflicting write.
        lat_min = 2; lat_max = 2;
        do_write(32'h204, 32'hD0, w);
        do_read(32'h200, w);
        chk("raw_empty", 64'(q.size()), 64'd0);
        drain_all();

        // Read latency on an empty buffer: one IDLE cycle plus SRAM latency.
        do_read(32'h400, w);
        chk("rd_lat_empty", 64'(w), 64'd3);

        // Repeated address behind a busy head.
        lat_min = 5; lat_max = 5;
        wr50_count = 0;
        do_write(32'h60, 32'h9, w);
        do_write(32'h50, 32'h1, w);
        do_write(32'h50, 32'h2, w);
        chk("coal_lat", 64'(w), 64'd0);
        drain_all();
`ifdef WB_COALESCE_EN
        exp50 = 1;
`else
        exp50 = 2;
`endif
        chk("coal_count", 64'(wr50_count), 64'(exp50));

        // Reset in the middle of a drain with three entries queued.
        lat_min = 8; lat_max = 8;
        do_write(32'h70, 32'hE0, w);
        do_write(32'h74, 32'hE1, w);
        do_write(32'h78, 32'hE2, w);
        step();
        chk("pre_rst_drain", 64'(sram_wr_en), 64'd1);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_rst_idle", 64'(sram_wr_en), 64'd0);
        end

        // Randomized traffic over a few colliding lines.
        lat_min = 0; lat_max = 3;
        for (int k = 0; k < 250; k++) begin
            int r;
            logic [31:0] a;
            r = int'($urandom_range(9, 0));
            a = 32'h1000 + ({28'd0, 4'($urandom_range(11, 0))} << 2);
            if (r < 6) do_write(a, $urandom(), w);
            else if (r < 8) do_read(a, w);
            else step();
        end
        drain_all();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
